cmd_route_cntrl: RTL and testbench

Command-and-control block for the line-following follower. It generalises single-destination go/stop control to a multi-stop route: destination IDs sit in a DEPTH-entry waypoint queue and are visited in order. The block sits between the UART command receiver / barcode reader flags (cmd_rdy, ID_vld) and the motion controller (go), and drives the piezo buzzer while the robot is blocked.

---
 rtl/cmd_route_cntrl.sv | 220 ++++++++++++++++++++++
 tb/tb_cmd_route_cntrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_route_cntrl.sv
// Multi-stop route command controller: waypoint queue, go/stop control and blocked-path buzzer.
// Optional define WAYPOINT_DWELL_EN adds a timed dwell at intermediate waypoints.
module cmd_route_cntrl #(
   parameter int unsigned ID_W         = 6,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned BUZZ_PERIOD  = 12500,
   parameter int unsigned DWELL_CYCLES = 50000000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ID_W+1:0]          cmd,
   input  logic                     cmd_rdy,
   input  logic [ID_W+1:0]          ID,
   input  logic                     ID_vld,
   input  logic                     OK2Move,
   output logic                     clr_cmd_rdy,
   output logic                     clr_ID_vld,
   output logic                     go,
   output logic                     in_transit,
   output logic                     buzz,
   output logic                     buzz_n,
   output logic [$clog2(DEPTH):0]   q_cnt,
   output logic                     arrived,
   output logic                     cmd_err
);

   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned BuzzW = $clog2(BUZZ_PERIOD);

   localparam logic [BuzzW-1:0] BuzzLast = BuzzW'(BUZZ_PERIOD - 1);
   localparam logic [BuzzW-1:0] BuzzHalf = BuzzW'(BUZZ_PERIOD / 2);
   localparam logic [PtrW:0]    QFull    = (PtrW+1)'(DEPTH);

   localparam logic [1:0] OpStop   = 2'b00;
   localparam logic [1:0] OpGo     = 2'b01;
   localparam logic [1:0] OpAppend = 2'b10;
   localparam logic [1:0] OpRun    = 2'b11;

   typedef enum logic [1:0] {StIdle, StMove, StDwell} state_e;

   state_e state_q, state_d;

   logic [ID_W-1:0]  mem [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    cnt_q;
   logic [BuzzW-1:0] buzz_cnt_q;
   logic             arrived_q, arrived_d;
   logic             cmd_err_q, cmd_err_d;
   logic             push, pop, flush;
   logic             buzz_en, dwell_done;

   logic [1:0]      op;
   logic [ID_W-1:0] cmd_id;
   logic            q_full, q_empty, id_match;

   assign op       = cmd[ID_W+1:ID_W];
   assign cmd_id   = cmd[ID_W-1:0];
   assign q_full   = (cnt_q == QFull);
   assign q_empty  = (cnt_q == '0);
   assign id_match = (ID[ID_W-1:0] == mem[rd_ptr_q]);

   // Barcode opcode bits are never compared.
   logic unused_id_op;
   assign unused_id_op = ^ID[ID_W+1:ID_W];

`ifdef WAYPOINT_DWELL_EN
   localparam int unsigned      DwellW    = $clog2(DWELL_CYCLES + 1);
   localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);

   logic [DwellW-1:0] dwell_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  dwell_cnt_q <= '0;
      else if (state_q == StDwell) dwell_cnt_q <= dwell_cnt_q + 1'b1;
      else                         dwell_cnt_q <= '0;
   end

   assign dwell_done = (dwell_cnt_q == DwellLast);
`else
   logic [31:0] unused_dwell_cycles;
   assign unused_dwell_cycles = 32'(DWELL_CYCLES);
   assign dwell_done          = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         arrived_q <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         arrived_q <= arrived_d;
         cmd_err_q <= cmd_err_d;
      end
   end

   // Next-state and queue control; cmd_rdy always wins over ID_vld.
   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;
      arrived_d = 1'b0;
      cmd_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_rdy) begin
               unique case (op)
                  OpStop:   flush = 1'b1;
                  OpGo: begin
                     flush   = 1'b1;
                     push    = 1'b1;
                     state_d = StMove;
                  end
                  OpAppend: begin
                     if (q_full) cmd_err_d = 1'b1;
                     else        push      = 1'b1;
                  end
                  OpRun: begin
                     if (q_empty) cmd_err_d = 1'b1;
                     else         state_d   = StMove;
                  end
               endcase
            end
         end
         StMove: begin
            if (cmd_rdy) begin
               unique case (op)
                  OpStop:   state_d = StIdle;
                  OpGo: begin
                     flush = 1'b1;
                     push  = 1'b1;
                  end
                  OpAppend: begin
                     if (q_full) cmd_err_d = 1'b1;
                     else        push      = 1'b1;
                  end
                  OpRun: ;
               endcase
            end else if (ID_vld && id_match) begin
               pop = 1'b1;
               if (cnt_q == (PtrW+1)'(1)) begin
                  state_d   = StIdle;
                  arrived_d = 1'b1;
               end
`ifdef WAYPOINT_DWELL_EN
               else begin
                  state_d = StDwell;
               end
`endif
            end
         end
         StDwell: begin
            state_d = dwell_done ? StMove : StDwell;
            if (cmd_rdy) begin
               unique case (op)
                  OpStop:   state_d = StIdle;
                  OpGo: begin
                     flush   = 1'b1;
                     push    = 1'b1;
                     state_d = StMove;
                  end
                  OpAppend: begin
                     if (q_full) cmd_err_d = 1'b1;
                     else        push      = 1'b1;
                  end
                  OpRun: ;
               endcase
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      in_transit  = (state_q != StIdle);
      go          = (state_q == StMove) & OK2Move;
      buzz_en     = (state_q == StMove) & ~OK2Move;
      buzz        = buzz_en & (buzz_cnt_q >= BuzzHalf);
      buzz_n      = buzz_en & (buzz_cnt_q < BuzzHalf);
      clr_cmd_rdy = cmd_rdy;
      clr_ID_vld  = ID_vld & ~cmd_rdy;
      arrived     = arrived_q;
      cmd_err     = cmd_err_q;
      q_cnt       = cnt_q;
   end

   // Waypoint queue pointers; a GO flush and its load land in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= push ? PtrW'(1) : '0;
         cnt_q    <= push ? (PtrW+1)'(1) : '0;
      end else if (push) begin
         wr_ptr_q <= wr_ptr_q + 1'b1;
         cnt_q    <= cnt_q + 1'b1;
      end else if (pop) begin
         rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q    <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[flush ? '0 : wr_ptr_q] <= cmd_id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         buzz_cnt_q <= '0;
      else if (!buzz_en)  buzz_cnt_q <= '0;
      else if (buzz_cnt_q == BuzzLast) buzz_cnt_q <= '0;
      else                buzz_cnt_q <= buzz_cnt_q + 1'b1;
   end

endmodule

// File: tb/tb_cmd_route_cntrl.sv
// Randomised self-checking bench for cmd_route_cntrl against a queue-based route model.
// Model honours WAYPOINT_DWELL_EN when the bench is built with it.
module tb_cmd_route_cntrl;

   localparam int unsigned ID_W         = 6;
   localparam int unsigned DEPTH        = 4;
   localparam int unsigned BUZZ_PERIOD  = 8;
   localparam int unsigned DWELL_CYCLES = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] cmd = '0;
   logic [7:0] ID = '0;
   logic       cmd_rdy = 1'b0;
   logic       ID_vld = 1'b0;
   logic       OK2Move = 1'b1;
   logic       clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n, arrived, cmd_err;
   logic [2:0] q_cnt;

   int n_checks = 0;
   int n_errs   = 0;

   // Route model: plain queue of IDs plus mode flags.
   int mq[$];
   bit m_mv, m_dw, m_arr, m_err;
   int m_bcnt, m_dleft;

   cmd_route_cntrl #(
      .ID_W        (ID_W),
      .DEPTH       (DEPTH),
      .BUZZ_PERIOD (BUZZ_PERIOD),
      .DWELL_CYCLES(DWELL_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cmd),
      .cmd_rdy    (cmd_rdy),
      .ID         (ID),
      .ID_vld     (ID_vld),
      .OK2Move    (OK2Move),
      .clr_cmd_rdy(clr_cmd_rdy),
      .clr_ID_vld (clr_ID_vld),
      .go         (go),
      .in_transit (in_transit),
      .buzz       (buzz),
      .buzz_n     (buzz_n),
      .q_cnt      (q_cnt),
      .arrived    (arrived),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_mv = 0; m_dw = 0; m_arr = 0; m_err = 0; m_bcnt = 0; m_dleft = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      cmd_rdy = 1'b0;
      ID_vld  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_in_transit", in_transit, 0);
      check_eq("rst_go", go, 0);
      check_eq("rst_buzz", buzz, 0);
      check_eq("rst_buzz_n", buzz_n, 0);
      check_eq("rst_q_cnt", q_cnt, 0);
      check_eq("rst_arrived", arrived, 0);
      check_eq("rst_cmd_err", cmd_err, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock: drive, check against the model, then advance the model.
   task automatic step(input bit cr, input logic [7:0] c, input bit iv, input logic [7:0] i,
                       input bit ok);
      bit en, was_idle, was_mv;
      int op, cid, iid;
      @(negedge clk);
      cmd_rdy = cr; cmd = c; ID_vld = iv; ID = i; OK2Move = ok;
      #1;
      en = m_mv && !ok;
      check_eq("clr_cmd_rdy", clr_cmd_rdy, cr);
      check_eq("clr_ID_vld", clr_ID_vld, iv && !cr);
      check_eq("in_transit", in_transit, m_mv || m_dw);
      check_eq("go", go, m_mv && ok);
      check_eq("buzz", buzz, en && (m_bcnt >= BUZZ_PERIOD / 2));
      check_eq("buzz_n", buzz_n, en && (m_bcnt < BUZZ_PERIOD / 2));
      check_eq("q_cnt", q_cnt, mq.size());
      check_eq("arrived", arrived, m_arr);
      check_eq("cmd_err", cmd_err, m_err);
      @(posedge clk);
      op = int'(c[7:6]); cid = int'(c[5:0]); iid = int'(i[5:0]);
      was_idle = !m_mv && !m_dw;
      was_mv   = m_mv;
      m_arr = 0; m_err = 0;
      m_bcnt = en ? (m_bcnt + 1) % BUZZ_PERIOD : 0;
      if (m_dw) begin
         m_dleft--;
         if (m_dleft == 0) begin m_dw = 0; m_mv = 1; end
      end
      if (cr) begin
         case (op)
            0: if (was_idle) mq.delete(); else begin m_mv = 0; m_dw = 0; end
            1: begin mq.delete(); mq.push_back(cid); m_mv = 1; m_dw = 0; end
            2: if (mq.size() == DEPTH) m_err = 1; else mq.push_back(cid);
            default: if (was_idle) begin
               if (mq.size() == 0) m_err = 1; else m_mv = 1;
            end
         endcase
      end else if (iv && was_mv && mq.size() > 0 && iid == mq[0]) begin
         void'(mq.pop_front());
         if (mq.size() == 0) begin
            m_mv = 0; m_arr = 1;
         end
`ifdef WAYPOINT_DWELL_EN
         else begin
            m_mv = 0; m_dw = 1; m_dleft = DWELL_CYCLES;
         end
`endif
      end
   endtask

   task automatic idle_steps(input int n);
      for (int k = 0; k < n; k++) step(0, 8'h00, 0, 8'h00, 1);
   endtask

   initial begin
      bit         cr, iv, ok;
      logic [7:0] c, i;
      model_reset();
      do_reset();

      // Single destination, mismatched then matching barcode.
      step(1, 8'h45, 0, 8'h00, 1);
      step(0, 8'h00, 1, 8'h07, 1);
      step(0, 8'h00, 1, 8'h05, 1);
      idle_steps(2);

      // Appended route run to completion.
      step(1, 8'h81, 0, 8'h00, 1);
      step(1, 8'h82, 0, 8'h00, 1);
      step(1, 8'h83, 0, 8'h00, 1);
      step(1, 8'hC0, 0, 8'h00, 1);
      step(0, 8'h00, 1, 8'h01, 1);
      idle_steps(DWELL_CYCLES + 1);
      step(0, 8'h00, 1, 8'h02, 1);
      idle_steps(DWELL_CYCLES + 1);
      step(0, 8'h00, 1, 8'h03, 1);
      idle_steps(2);

      // Queue overflow, STOP flush in idle, RUN on empty queue.
      for (int k = 1; k <= 5; k++) step(1, 8'h80 | 8'(k), 0, 8'h00, 1);
      step(1, 8'h00, 0, 8'h00, 1);
      step(1, 8'hC0, 0, 8'h00, 1);
      idle_steps(2);

      // STOP and matching barcode together, then resume at the same head.
      step(1, 8'h45, 0, 8'h00, 1);
      step(1, 8'h86, 0, 8'h00, 1);
      step(1, 8'h00, 1, 8'h05, 1);
      step(1, 8'hC0, 0, 8'h00, 1);
      step(0, 8'h00, 1, 8'h05, 1);
      idle_steps(DWELL_CYCLES + 1);
      step(0, 8'h00, 1, 8'h06, 1);
      idle_steps(2);

      // Blocked path: buzzer runs, then clears.
      step(1, 8'h47, 0, 8'h00, 1);
      for (int k = 0; k < 20; k++) step(0, 8'h00, 0, 8'h00, 0);
      idle_steps(3);
      step(0, 8'h00, 1, 8'h07, 1);
      idle_steps(2);

      // Reset mid-route with three queued waypoints.
      step(1, 8'h81, 0, 8'h00, 1);
      step(1, 8'h82, 0, 8'h00, 1);
      step(1, 8'h83, 0, 8'h00, 1);
      step(1, 8'hC0, 0, 8'h00, 1);
      step(0, 8'h00, 0, 8'h00, 0);
      do_reset();

      // Randomised traffic with bursty obstacles and frequent head matches.
      ok = 1;
      for (int n = 0; n < 3000; n++) begin
         if (n % 600 == 599) do_reset();
         cr = ($urandom_range(3) == 0);
         c  = 8'($urandom_range(255));
         c[5:0] = 6'($urandom_range(7));
         iv = ($urandom_range(2) == 0);
         i  = 8'($urandom_range(255));
         if (mq.size() > 0 && $urandom_range(1) == 1) i[5:0] = 6'(mq[0]);
         else i[5:0] = 6'($urandom_range(7));
         if ($urandom_range(15) == 0) ok = !ok;
         step(cr, c, iv, i, ok);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
